// File: rtl/lab_adc_ctrl.sv
// lab_adc_ctrl: Wilkinson-ADC conversion sequencer driving per-chip CLR/RAMP and GCK enable.
// All outputs are registered so they can be packed into IOB flops.
module lab_adc_ctrl #(
    parameter int NCHIP    = 4,
    parameter int CNT_BITS = 12,
    parameter int CLR_BITS = 5
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                read_done_i,
    input  logic [NCHIP-1:0]    chip_mask_i,
    input  logic [CLR_BITS-1:0] clr_len_i,
    input  logic [CNT_BITS-1:0] count_max_i,
    output logic [NCHIP-1:0]    CLR,
    output logic [NCHIP-1:0]    RAMP,
    output logic                gck_en_o,
    output logic [CNT_BITS-1:0] count_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o
);
    typedef enum logic [2:0] {IDLE, CLEAR, COUNT, DONE, HOLD} state_t;

    state_t              state_q;
    logic [1:0]          rst_sync_q;
    logic                rst_n;
    logic [NCHIP-1:0]    mask_q, clr_q, ramp_q;
    logic [CLR_BITS-1:0] len_q, len_d, clr_cnt_q;
    logic [CNT_BITS-1:0] max_q, count_q;
    logic                gck_q, busy_q, done_q, aborted_q;

    // Reset asserts asynchronously but is released only after two clean clock edges
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};

    assign rst_n = rst_sync_q[1];
    assign len_d = (clr_len_i == '0) ? CLR_BITS'(1) : clr_len_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            len_q     <= '0;
            max_q     <= '0;
            clr_cnt_q <= '0;
            count_q   <= '0;
            clr_q     <= '0;
            ramp_q    <= '0;
            gck_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (state_q != IDLE && abort_i) begin
                state_q   <= IDLE;
                clr_q     <= '0;
                ramp_q    <= '0;
                gck_q     <= 1'b0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE:
                        if (start_i && |chip_mask_i) begin
                            state_q   <= CLEAR;
                            mask_q    <= chip_mask_i;
                            len_q     <= len_d;
                            max_q     <= count_max_i;
                            clr_cnt_q <= CLR_BITS'(1);
                            clr_q     <= chip_mask_i;
                            count_q   <= '0;
                            busy_q    <= 1'b1;
                        end
                    CLEAR:
                        if (clr_cnt_q == len_q) begin
                            state_q <= COUNT;
                            clr_q   <= '0;
                            ramp_q  <= mask_q;
                            gck_q   <= 1'b1;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    // Stop on the compare rather than overflow so all-ones never wraps
                    COUNT:
                        if (count_q == max_q) begin
                            state_q <= DONE;
                            gck_q   <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    DONE, HOLD:
                        if (read_done_i) begin
                            state_q <= IDLE;
                            ramp_q  <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= HOLD;
                        end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign CLR       = clr_q;
    assign RAMP      = ramp_q;
    assign gck_en_o  = gck_q;
    assign count_o   = count_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign aborted_o = aborted_q;
endmodule

// File: tb/tb_lab_adc_ctrl.sv
// tb_lab_adc_ctrl: table-driven per-cycle vectors plus long-run, abort and async-reset sequences.
module tb_lab_adc_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0, read_done_i = 1'b0;
    logic [3:0]  chip_mask_i = '0;
    logic [4:0]  clr_len_i = '0;
    logic [11:0] count_max_i = '0;
    logic [3:0]  CLR, RAMP;
    logic        gck_en_o, busy_o, done_o, aborted_o;
    logic [11:0] count_o;

    int pass_cnt = 0;
    int total = 0;

    lab_adc_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .read_done_i(read_done_i), .chip_mask_i(chip_mask_i), .clr_len_i(clr_len_i),
        .count_max_i(count_max_i), .CLR(CLR), .RAMP(RAMP), .gck_en_o(gck_en_o),
        .count_o(count_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st, ab, rd;
        logic [3:0]  m;
        logic [4:0]  cl;
        logic [11:0] cm;
        logic [3:0]  clr, ramp;
        logic        gck;
        logic [11:0] cnt;
        logic        busy, done, abt;
    } vec_t;

    vec_t vecs [30];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] outs();
        return {CLR, RAMP, gck_en_o, count_o, busy_o, done_o, aborted_o};
    endfunction

    int cyc, clr_first, clr_last, clr_n, gck_first, gck_last, gck_n, done_n, done_cyc;
    logic [11:0] cnt_at_done;
    logic bad, found;

    initial begin
        // Short conversion L=2 M=3 mask 0101 with HOLD, idle-time noise
        vecs[0]  = '{1'b1,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h5,4'h0,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h5,4'h0,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h5,1'b1,12'd0,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h5,1'b1,12'd1,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h5,1'b1,12'd2,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h5,1'b1,12'd3,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h5,1'b0,12'd3,1'b1,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h5,1'b0,12'd3,1'b1,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,4'h5,5'd2,12'd3, 4'h0,4'h0,1'b0,12'd3,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,4'h5,5'd2,12'd3, 4'h0,4'h0,1'b0,12'd3,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,4'h0,5'd2,12'd3, 4'h0,4'h0,1'b0,12'd3,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,4'h5,5'd2,12'd3, 4'h0,4'h0,1'b0,12'd3,1'b0,1'b0,1'b0};
        // L=0 treated as 1, M=0; abort beats read_done in DONE
        vecs[12] = '{1'b1,1'b0,1'b0,4'hA,5'd0,12'd0, 4'hA,4'h0,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,4'hA,5'd0,12'd0, 4'h0,4'hA,1'b1,12'd0,1'b1,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,4'hA,5'd0,12'd0, 4'h0,4'hA,1'b0,12'd0,1'b1,1'b1,1'b0};
        vecs[15] = '{1'b0,1'b1,1'b1,4'hA,5'd0,12'd0, 4'h0,4'h0,1'b0,12'd0,1'b0,1'b0,1'b1};
        vecs[16] = '{1'b0,1'b0,1'b0,4'hA,5'd0,12'd0, 4'h0,4'h0,1'b0,12'd0,1'b0,1'b0,1'b0};
        // Inputs changed mid-conversion are ignored; read_done in DONE releases directly
        vecs[17] = '{1'b1,1'b0,1'b0,4'hF,5'd1,12'd1, 4'hF,4'h0,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,4'h0,5'd20,12'd0, 4'h0,4'hF,1'b1,12'd0,1'b1,1'b0,1'b0};
        vecs[19] = '{1'b0,1'b0,1'b0,4'h0,5'd20,12'd0, 4'h0,4'hF,1'b1,12'd1,1'b1,1'b0,1'b0};
        vecs[20] = '{1'b0,1'b0,1'b0,4'h0,5'd20,12'd0, 4'h0,4'hF,1'b0,12'd1,1'b1,1'b1,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b1,4'h0,5'd20,12'd0, 4'h0,4'h0,1'b0,12'd1,1'b0,1'b0,1'b0};
        // Abort during CLEAR
        vecs[22] = '{1'b1,1'b0,1'b0,4'h3,5'd5,12'd9, 4'h3,4'h0,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[23] = '{1'b0,1'b1,1'b0,4'h3,5'd5,12'd9, 4'h0,4'h0,1'b0,12'd0,1'b0,1'b0,1'b1};
        vecs[24] = '{1'b0,1'b0,1'b0,4'h3,5'd5,12'd9, 4'h0,4'h0,1'b0,12'd0,1'b0,1'b0,1'b0};
        // Abort and read_done together in HOLD
        vecs[25] = '{1'b1,1'b0,1'b0,4'h1,5'd1,12'd0, 4'h1,4'h0,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[26] = '{1'b0,1'b0,1'b0,4'h1,5'd1,12'd0, 4'h0,4'h1,1'b1,12'd0,1'b1,1'b0,1'b0};
        vecs[27] = '{1'b0,1'b0,1'b0,4'h1,5'd1,12'd0, 4'h0,4'h1,1'b0,12'd0,1'b1,1'b1,1'b0};
        vecs[28] = '{1'b0,1'b0,1'b0,4'h1,5'd1,12'd0, 4'h0,4'h1,1'b0,12'd0,1'b1,1'b0,1'b0};
        vecs[29] = '{1'b0,1'b1,1'b1,4'h1,5'd1,12'd0, 4'h0,4'h0,1'b0,12'd0,1'b0,1'b0,1'b1};

        #12;
        chk("reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) tick();
        chk("post_reset_outputs", 64'(outs()), 64'd0);

        for (int i = 0; i < 30; i++) begin
            start_i = vecs[i].st; abort_i = vecs[i].ab; read_done_i = vecs[i].rd;
            chip_mask_i = vecs[i].m; clr_len_i = vecs[i].cl; count_max_i = vecs[i].cm;
            tick();
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].clr, vecs[i].ramp, vecs[i].gck, vecs[i].cnt,
                     vecs[i].busy, vecs[i].done, vecs[i].abt}));
        end
        start_i = 0; abort_i = 0; read_done_i = 0;

        // Full-range conversion L=16, M=4095
        chip_mask_i = 4'h5; clr_len_i = 5'd16; count_max_i = 12'd4095;
        clr_first = 0; clr_last = 0; clr_n = 0; gck_first = 0; gck_last = 0; gck_n = 0;
        done_n = 0; done_cyc = 0; cnt_at_done = '0;
        start_i = 1;
        for (cyc = 1; cyc <= 4120; cyc++) begin
            tick();
            start_i = 0;
            if (CLR == 4'h5) begin
                if (clr_first == 0) clr_first = cyc;
                clr_last = cyc; clr_n++;
            end
            if (gck_en_o) begin
                if (gck_first == 0) gck_first = cyc;
                gck_last = cyc; gck_n++;
            end
            if (done_o) begin
                done_n++; done_cyc = cyc; cnt_at_done = count_o;
            end
        end
        chk("long_clr_first", 64'(clr_first), 64'd1);
        chk("long_clr_last", 64'(clr_last), 64'd16);
        chk("long_clr_len", 64'(clr_n), 64'd16);
        chk("long_gck_first", 64'(gck_first), 64'd17);
        chk("long_gck_last", 64'(gck_last), 64'd4112);
        chk("long_gck_len", 64'(gck_n), 64'd4096);
        chk("long_done_pulses", 64'(done_n), 64'd1);
        chk("long_done_cycle", 64'(done_cyc), 64'd4113);
        chk("long_count_at_done", 64'(cnt_at_done), 64'd4095);

        // HOLD: 50 cycles after done with read_done low, start pulses ignored
        bad = 1'b0;
        for (int i = 0; i < 43; i++) begin
            start_i = i[0];
            tick();
            if (RAMP != 4'h5 || CLR != 4'h0 || !busy_o || count_o != 12'd4095) bad = 1'b1;
        end
        chk("hold_stable", 64'(bad), 64'd0);
        read_done_i = 1; start_i = 1;
        tick();
        read_done_i = 0; start_i = 0;
        chk("hold_release", 64'({RAMP, busy_o, count_o}), 64'({4'h0, 1'b0, 12'd4095}));
        tick();
        chk("reenter_start_ignored", 64'({CLR, busy_o}), 64'd0);

        // Abort in the 100th COUNT cycle
        chip_mask_i = 4'hF; clr_len_i = 5'd3; count_max_i = 12'd500;
        start_i = 1;
        tick();
        start_i = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (gck_en_o && count_o == 12'd99) found = 1'b1;
        end
        chk("abort_reach_99", 64'(found), 64'd1);
        abort_i = 1;
        tick();
        abort_i = 0;
        chk("abort_outputs", 64'(outs()), 64'({4'h0, 4'h0, 1'b0, 12'd99, 1'b0, 1'b0, 1'b1}));
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_o || aborted_o || busy_o || count_o != 12'd99) bad = 1'b1;
        end
        chk("abort_aftermath", 64'(bad), 64'd0);

        // Asynchronous reset mid-COUNT
        chip_mask_i = 4'h3; clr_len_i = 5'd2; count_max_i = 12'd100;
        start_i = 1;
        tick();
        start_i = 0;
        repeat (10) tick();
        chk("pre_reset_counting", 64'({gck_en_o, busy_o}), 64'b11);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) tick();
        chk("after_async_reset", 64'(outs()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
